// File: rtl/quad_pe_ctrl_if.sv
// quad_pe_ctrl_if: job config, operand beat handshake, Quad_PE controls and OFM handshake of quad_pe_ctrl.
interface quad_pe_ctrl_if;
  logic start;
  logic [7:0] cfg_groups;
  logic [15:0] cfg_outputs;
  logic in_valid;
  logic in_ready;
  logic pe_op_en;
  logic PE_reset;
  logic PE_finish;
  logic [7:0] grp_idx;
  logic [15:0] out_idx;
  logic ofm_valid;
  logic ofm_ready;
  logic busy;
  logic done;
  modport master (
    output start, cfg_groups, cfg_outputs, in_valid, ofm_ready,
    input in_ready, pe_op_en, PE_reset, PE_finish, grp_idx, out_idx, ofm_valid, busy, done
  );
  modport slave (
    input start, cfg_groups, cfg_outputs, in_valid, ofm_ready,
    output in_ready, pe_op_en, PE_reset, PE_finish, grp_idx, out_idx, ofm_valid, busy, done
  );
endinterface

// File: rtl/quad_pe_ctrl.sv
// quad_pe_ctrl: sequences operand groups into a Quad_PE per output pixel and hands finished pixels out.
// Defining QUAD_PE_CTRL_PERF_EN adds the stall_cnt port and its saturating counter.
module quad_pe_ctrl (
  input  logic clk,
  input  logic reset,
  quad_pe_ctrl_if.slave bus
`ifdef QUAD_PE_CTRL_PERF_EN
  , output logic [31:0] stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, WAIT_OUT, DONE} state_t;
  state_t state, state_d;
  logic [7:0] groups, grp_idx, grp_d;
  logic [15:0] outputs, out_idx, out_d;
  logic launch, accept, last_grp, last_out, out_take;
  assign launch = state == IDLE && bus.start;
  assign accept = state == RUN && bus.in_valid;
  assign out_take = state == WAIT_OUT && bus.ofm_ready;
  assign last_grp = grp_idx == groups - 8'd1;
  assign last_out = out_idx == outputs - 16'd1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grp_idx <= '0;
      out_idx <= '0;
      groups <= 8'd1;
      outputs <= '0;
    end else begin
      state <= state_d;
      grp_idx <= grp_d;
      out_idx <= out_d;
      if (launch) begin
        groups <= bus.cfg_groups == 8'd0 ? 8'd1 : bus.cfg_groups;
        outputs <= bus.cfg_outputs;
      end
    end
  end
  // Counters are zeroed on launch and on entry to DONE, so an idle controller always reads 0/0.
  always_comb begin
    state_d = state;
    grp_d = grp_idx;
    out_d = out_idx;
    if (launch) begin
      state_d = bus.cfg_outputs == 16'd0 ? DONE : RUN;
      grp_d = '0;
      out_d = '0;
    end
    if (accept) begin
      grp_d = last_grp ? 8'd0 : grp_idx + 8'd1;
      state_d = last_grp ? WAIT_OUT : RUN;
    end
    if (out_take) begin
      state_d = last_out ? DONE : RUN;
      out_d = last_out ? 16'd0 : out_idx + 16'd1;
    end
    if (state == DONE) state_d = IDLE;
  end
  assign bus.in_ready = state == RUN;
  assign bus.pe_op_en = accept;
  assign bus.PE_reset = accept && grp_idx == 8'd0;
  assign bus.PE_finish = accept && last_grp;
  assign bus.grp_idx = grp_idx;
  assign bus.out_idx = out_idx;
  assign bus.ofm_valid = state == WAIT_OUT;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
`ifdef QUAD_PE_CTRL_PERF_EN
  logic stall;
  assign stall = (state == RUN && !bus.in_valid) || (state == WAIT_OUT && !bus.ofm_ready);
  always_ff @(posedge clk) begin
    if (reset || launch) stall_cnt <= '0;
    else if (stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule
